// File: rtl/ccff_config_ctrl.sv
// Configuration-chain controller: clears the fabric's configuration flip-flop chain,
// serializes bitstream words into its head, and checks that the tail stays clear.
module ccff_config_ctrl #(
    parameter int WORD_W     = 8,
    parameter int CHAIN_LEN  = 64,
    parameter int CLR_CYCLES = 2,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              chain_reset,
    output logic              chain_shift_en,
    output logic              chain_head,
    input  logic              chain_tail,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  bit_cnt
);

    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);
    localparam logic [CLR_W-1:0] LAST_CLR = CLR_W'(CLR_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t            state;
    logic [WORD_W-1:0] shreg;
    logic [IDX_W-1:0]  word_idx;
    logic [CLR_W-1:0]  clr_cnt;
    logic              abort_hit;

    // Abort is meaningless in IDLE, so it only counts once a sequence is running.
    assign abort_hit = abort && (state != S_IDLE);

    // NOTE: every register here is plain state (no memory arrays), so all of it is
    // cleared by the asynchronous reset, including the shift register and counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            shreg          <= '0;
            word_idx       <= '0;
            clr_cnt        <= '0;
            s_ready        <= 1'b0;
            chain_reset    <= 1'b0;
            chain_shift_en <= 1'b0;
            chain_head     <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            bit_cnt        <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch below reads
            // the pre-edge values (e.g. shreg[1] is the next bit before the shift).
            done <= 1'b0;

            if (abort_hit) begin
                // Abort wins over any handshake or shift completing on this edge.
                state          <= S_IDLE;
                s_ready        <= 1'b0;
                chain_reset    <= 1'b0;
                chain_shift_en <= 1'b0;
                chain_head     <= 1'b0;
                busy           <= 1'b0;
                err            <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state       <= S_CLEAR;
                            busy        <= 1'b1;
                            chain_reset <= 1'b1;
                            clr_cnt     <= '0;
                            err         <= 1'b0;
                            bit_cnt     <= '0;
                        end
                    end

                    S_CLEAR: begin
                        if (clr_cnt == LAST_CLR) begin
                            state       <= S_LOAD;
                            chain_reset <= 1'b0;
                            s_ready     <= 1'b1;
                        end else begin
                            clr_cnt <= clr_cnt + 1'b1;
                        end
                    end

                    S_LOAD: begin
                        if (s_valid) begin
                            state          <= S_SHIFT;
                            s_ready        <= 1'b0;
                            shreg          <= s_data;
                            word_idx       <= '0;
                            chain_shift_en <= 1'b1;
                            chain_head     <= s_data[0];
                        end
                    end

                    S_SHIFT: begin
                        // The tail is sampled on the shift edge, before the chain moves.
                        if (chain_tail) begin
                            err <= 1'b1;
                        end
                        shreg      <= shreg >> 1;
                        chain_head <= shreg[1];
                        word_idx   <= word_idx + 1'b1;
                        bit_cnt    <= bit_cnt + 1'b1;

                        if (bit_cnt == LAST_BIT) begin
                            // Chain full: any bits left in the current word are dropped.
                            state          <= S_DONE;
                            done           <= 1'b1;
                            chain_shift_en <= 1'b0;
                            chain_head     <= 1'b0;
                        end else if (word_idx == LAST_IDX) begin
                            state          <= S_LOAD;
                            s_ready        <= 1'b1;
                            chain_shift_en <= 1'b0;
                            chain_head     <= 1'b0;
                        end
                    end

                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end

                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ccff_config_ctrl.sv
// Bench for ccff_config_ctrl: table of programming scenarios on a 64-cell chain plus
// hand-written sequences for start/abort priority, a 60-cell chain and async reset.
module tb_ccff_config_ctrl;

    localparam int LIMIT = 400;

    typedef struct {
        logic [95:0] name;
        logic [7:0]  base;
        logic [7:0]  step;
        int          stall_after;
        int          stall_len;
        int          fault_at;
        int          abort_at;
        int          exp_done;
        int          exp_err;
        int          exp_cnt;
        int          exp_cycles;
    } scn_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n = 1'b0;
    logic       start   = 1'b0;
    logic       abort   = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data  = 8'h00;

    logic        ready_a, creset_a, shift_a, head_a, tail_a, busy_a, done_a, err_a;
    logic [15:0] cnt_a;
    logic        ready_b, creset_b, shift_b, head_b, tail_b, busy_b, done_b, err_b;
    logic [15:0] cnt_b;

    ccff_config_ctrl #(.WORD_W(8), .CHAIN_LEN(64), .CLR_CYCLES(2), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .s_data(s_data), .s_valid(s_valid), .s_ready(ready_a),
        .chain_reset(creset_a), .chain_shift_en(shift_a), .chain_head(head_a),
        .chain_tail(tail_a), .busy(busy_a), .done(done_a), .err(err_a), .bit_cnt(cnt_a)
    );

    ccff_config_ctrl #(.WORD_W(8), .CHAIN_LEN(60), .CLR_CYCLES(2), .CNT_W(16)) dut60 (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .s_data(s_data), .s_valid(s_valid), .s_ready(ready_b),
        .chain_reset(creset_b), .chain_shift_en(shift_b), .chain_head(head_b),
        .chain_tail(tail_b), .busy(busy_b), .done(done_b), .err(err_b), .bit_cnt(cnt_b)
    );

    // Chain models: cleared by chain_reset, shift in chain_head on enabled edges.
    logic [63:0] chain_a  = '0;
    logic [59:0] chain_b  = '0;
    int          shifts_a = 0;
    int          shifts_b = 0;
    int          fault_at = -1;

    always @(posedge clk) begin
        if (creset_a) begin
            chain_a  <= '0;
            shifts_a <= 0;
        end else if (shift_a) begin
            chain_a  <= {chain_a[62:0], head_a};
            shifts_a <= shifts_a + 1;
        end
    end

    always @(posedge clk) begin
        if (creset_b) begin
            chain_b  <= '0;
            shifts_b <= 0;
        end else if (shift_b) begin
            chain_b  <= {chain_b[58:0], head_b};
            shifts_b <= shifts_b + 1;
        end
    end

    assign tail_a = chain_a[63] | (shift_a && (shifts_a == fault_at));
    assign tail_b = chain_b[59];

    // View of whichever instance the current test is aimed at.
    logic        sel = 1'b0;
    logic        m_ready, m_creset, m_shift, m_busy, m_done, m_err;
    logic [15:0] m_cnt;
    logic [63:0] m_chain;
    int          m_shifts;

    always_comb begin
        m_ready  = ready_a;
        m_creset = creset_a;
        m_shift  = shift_a;
        m_busy   = busy_a;
        m_done   = done_a;
        m_err    = err_a;
        m_cnt    = cnt_a;
        m_chain  = chain_a;
        m_shifts = shifts_a;
        if (sel) begin
            m_ready  = ready_b;
            m_creset = creset_b;
            m_shift  = shift_b;
            m_busy   = busy_b;
            m_done   = done_b;
            m_err    = err_b;
            m_cnt    = cnt_b;
            m_chain  = {4'b0000, chain_b};
            m_shifts = shifts_b;
        end
    end

    int    checks   = 0;
    int    failures = 0;
    string cur      = "reset";
    scn_t  tbl[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s: got %0h expected %0h", cur, name, act, exp);
        end
    endtask

    function automatic logic [7:0] word_of(input scn_t s, input int k);
        return s.base + 8'(k) * s.step;
    endfunction

    function automatic logic [63:0] exp_chain(input scn_t s, input int len);
        logic [63:0] v;
        logic [7:0]  w;
        v = '0;
        for (int i = 0; i < len; i++) begin
            w = word_of(s, i / 8);
            v[len - 1 - i] = w[i % 8];
        end
        return v;
    endfunction

    task automatic run_scenario(input scn_t s, input int len, output int words_out);
        int words = 0;
        int stall_left;
        int cycles = 1;
        int done_cnt = 0;
        int done_at = -1;
        int creset_cycles = 0;
        int overlap = 0;
        int err_first = -1;
        int after_abort = 0;
        bit aborted = 0;
        bit just_ab = 0;
        stall_left = s.stall_len;
        cur = $sformatf("%s", s.name);
        fault_at = s.fault_at;

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_err", m_err, 0);
        check("start_cnt", m_cnt, 0);
        check("start_busy", m_busy, 1);

        while (cycles < LIMIT) begin
            if (m_done) begin
                done_cnt++;
                if (done_at < 0) done_at = cycles;
            end
            if (m_creset) creset_cycles++;
            if (m_creset && m_shift) overlap++;
            if (m_err && err_first < 0) err_first = m_shifts;
            if (just_ab) begin
                check("abort_shift_en", m_shift, 0);
                check("abort_busy", m_busy, 0);
                check("abort_err", m_err, 1);
                just_ab = 0;
            end
            if (aborted) begin
                after_abort++;
                if (after_abort >= 4) break;
            end else if (!m_busy) begin
                break;
            end

            abort = 1'b0;
            if (s.abort_at >= 0 && !aborted && m_shift && m_shifts == s.abort_at) begin
                abort   = 1'b1;
                aborted = 1;
                just_ab = 1;
                s_valid = 1'b0;
            end else if (m_ready && words == s.stall_after && stall_left > 0) begin
                s_valid = 1'b0;
                stall_left--;
                check("stall_shift_en", m_shift, 0);
                check("stall_cnt", m_cnt, 8 * s.stall_after);
            end else if (m_ready) begin
                s_valid = 1'b1;
                s_data  = word_of(s, words);
                words++;
            end else begin
                s_valid = 1'b0;
            end
            @(negedge clk);
            cycles++;
        end
        abort   = 1'b0;
        s_valid = 1'b0;
        fault_at = -1;

        check("in_budget", cycles < LIMIT, 1);
        check("done_pulses", done_cnt, s.exp_done);
        check("final_err", m_err, s.exp_err);
        check("final_cnt", m_cnt, s.exp_cnt);
        check("clear_cycles", creset_cycles, 2);
        check("reset_shift_overlap", overlap, 0);
        if (s.exp_cycles > 0) check("start_to_done", done_at, s.exp_cycles);
        if (s.exp_done != 0) begin
            check("shift_edges", m_shifts, len);
            check("chain_contents", m_chain, exp_chain(s, len));
        end
        if (s.fault_at >= 0) check("err_rise_shift", err_first, s.fault_at + 1);
        words_out = words;
    endtask

    initial begin
        int   n;
        int   words;
        logic hi;
        scn_t pscn;

        //           name          base   step   stl ln flt abt dn er cnt cyc
        tbl[0] = '{"nominal",    8'hA5, 8'h00, -1, 0, -1, -1, 1, 0, 64, 75};
        tbl[1] = '{"varied",     8'h01, 8'h37, -1, 0, -1, -1, 1, 0, 64, 75};
        tbl[2] = '{"stall",      8'hA5, 8'h00,  3, 5, -1, -1, 1, 0, 64, 80};
        tbl[3] = '{"tail_fault", 8'h3C, 8'h11, -1, 0, 10, -1, 1, 1, 64, 75};
        tbl[4] = '{"after_flt",  8'hA5, 8'h00, -1, 0, -1, -1, 1, 0, 64, 75};
        tbl[5] = '{"abort",      8'h96, 8'h05, -1, 0, -1, 13, 0, 1, 13,  0};
        tbl[6] = '{"after_abt",  8'hA5, 8'h00, -1, 0, -1, -1, 1, 0, 64, 75};

        #12;
        check("reset_outputs_a", {ready_a, creset_a, shift_a, head_a, busy_a, done_a, err_a, cnt_a}, 0);
        check("reset_outputs_b", {ready_b, creset_b, shift_b, head_b, busy_b, done_b, err_b, cnt_b}, 0);
        @(negedge clk);
        reset_n = 1'b1;

        sel = 1'b0;
        for (int i = 0; i < 7; i++) begin
            run_scenario(tbl[i], 64, words);
        end

        // start and abort together in IDLE: start wins; start while busy is ignored.
        cur = "corner";
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_beats_abort_busy", m_busy, 1);
        check("start_beats_abort_clear", m_creset, 1);
        n = 0;
        while (!m_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("reach_load", n < 20, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_start_ready", m_ready, 1);
        check("busy_start_no_clear", m_creset, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("load_abort_busy", m_busy, 0);
        check("load_abort_err", m_err, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("idle_abort_ignored", m_busy, 0);

        // Shorter chain: the last word is only half shifted.
        sel  = 1'b1;
        pscn = '{"partial60", 8'hA5, 8'h22, -1, 0, -1, -1, 1, 0, 60, 71};
        run_scenario(pscn, 60, words);
        check("handshakes", words, 8);
        hi = 1'b0;
        for (int i = 0; i < 4; i++) begin
            hi = hi | ready_b;
            @(negedge clk);
        end
        check("ready_low_after_last", hi, 0);

        // Asynchronous reset in the middle of shifting.
        sel = 1'b0;
        cur = "async_reset";
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(m_shift && m_shifts >= 20) && n < 100) begin
            s_valid = m_ready;
            s_data  = 8'h5A;
            @(negedge clk);
            n++;
        end
        s_valid = 1'b0;
        check("reach_shift", n < 100, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("outputs_cleared", {ready_a, creset_a, shift_a, head_a, busy_a, done_a, err_a, cnt_a}, 0);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        check("held_busy", busy_a, 0);
        @(negedge clk);
        check("held_outputs", {ready_a, creset_a, shift_a, done_a, cnt_a}, 0);
        start = 1'b0;
        abort = 1'b0;
        #2;
        reset_n = 1'b1;
        hi = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            hi = hi | done_a | busy_a;
        end
        check("no_done_after_reset", hi, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ccff_config_ctrl.md
Name: ccff_config_ctrl

Overview:
Configuration-chain controller for the FPGA fabric.
- Accepts bitstream words over a valid/ready stream.
- Clears the scan chain of configuration flip-flops, then serializes the words into the chain head, one bit per enabled clock, until exactly CHAIN_LEN bits are loaded.
- Monitors the chain tail for integrity errors and sits between the bitstream loader and the fabric's configuration chain.

Parameters:
- WORD_W, 8: bits per input bitstream word.
- CHAIN_LEN, 64: number of flip-flops in the chain; total bits to shift.
- CLR_CYCLES, 2: cycles chain_reset is held high before loading.
- CNT_W, 16: width of the bit counter; must satisfy 2^CNT_W > CHAIN_LEN.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a programming sequence; honoured only in IDLE.
- abort  in  1  aborts the sequence from any non-IDLE state.
- s_data  in  WORD_W  bitstream word; bit 0 is shifted first.
- s_valid  in  1  word valid.
- s_ready  out  1  word accepted when s_valid && s_ready at a clk edge.
- chain_reset  out  1  active-high clear to all chain cells.
- chain_shift_en  out  1  chain cells capture chain_head at the next clk edge.
- chain_head  out  1  serial data into the first cell.
- chain_tail  in  1  output of the last cell.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when CHAIN_LEN bits have been shifted.
- err  out  1  sticky error flag; cleared by start or reset.
- bit_cnt  out  CNT_W  bits shifted so far in the current sequence.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = IDLE.
  - All outputs 0: s_ready, chain_reset, chain_shift_en, chain_head, busy, done, err, bit_cnt.
  - Shift register and counters cleared.
- All outputs are registered.
- States and transitions:
  - IDLE: start -> CLEAR; err and bit_cnt are cleared on the same edge.
  - CLEAR: chain_reset = 1 for exactly CLR_CYCLES cycles -> LOAD.
  - LOAD: s_ready = 1. On handshake, capture s_data into the shift register and reset the word-bit index to 0 -> SHIFT. s_ready drops the cycle after the handshake.
  - SHIFT: each cycle, chain_shift_en = 1 and chain_head = shreg[0].
    - On each shift edge, shreg shifts right and bit_cnt increments.
    - chain_tail is sampled on the same edge, i.e. before the chain advances.
    - After WORD_W shifts with bit_cnt < CHAIN_LEN -> LOAD.
    - When bit_cnt reaches CHAIN_LEN (this may be mid-word) -> DONE. The remaining word bits are discarded.
  - DONE: done = 1 for one cycle -> IDLE.
- Gaps and latency:
  - chain_shift_en is 0 in LOAD, so the chain holds its state while waiting for s_valid. Arbitrary input gaps are legal.
  - Handshake to first chain_shift_en is 1 cycle.
  - Back-to-back words leave a 1-cycle LOAD gap between them.
  - A full load takes CLR_CYCLES + CHAIN_LEN + ceil(CHAIN_LEN/WORD_W) + 1 cycles from start to done, with s_valid held high.
- Integrity check:
  - The chain was cleared, so chain_tail must read 0 on every one of the CHAIN_LEN shift edges.
  - Any 1 sets err, which is sticky. The sequence still completes and done still pulses.
- Abort:
  - In CLEAR, LOAD, SHIFT or DONE, abort -> IDLE on the next edge.
  - chain_shift_en drops immediately on that edge, err is set, and done is not pulsed.
  - Abort has priority over any handshake or shift completing on the same edge.
- Simultaneous events:
  - start while busy is ignored.
  - start and abort together in IDLE: start wins. abort is ignored in IDLE.
- chain_reset is never high at the same time as chain_shift_en.
- Mid-operation reset: everything returns to reset values asynchronously. No done pulse. The chain contents are undefined until the next start.

Test Plan:
- Nominal load (WORD_W=8, CHAIN_LEN=64, CLR_CYCLES=2): start, then 8 words 0xA5 sent back-to-back with the tail model at 0.
  - chain_reset high 2 cycles.
  - 64 shift edges; chain_head sequence per word is 1,0,1,0,0,1,0,1.
  - done pulses once, 75 cycles after start; err = 0; bit_cnt = 64.
  - Chain model contents equal the serialized stream.
- Partial final word (CHAIN_LEN=60): 8 words sent -> exactly 60 shift edges; the last word's bits 4-7 are never driven; done pulses; s_ready stays 0 after the 8th handshake.
- Stalled input: s_valid drops for 5 cycles after word 3 -> chain_shift_en stays 0 for those cycles; bit_cnt holds at 24; the final chain contents are identical to the nominal case.
- Tail fault: the chain model drives chain_tail = 1 on shift 10 -> err rises on that edge and stays high; done still pulses; the next start clears err.
- Abort mid-shift: abort asserted at bit_cnt = 13 -> IDLE next edge; chain_shift_en = 0; err = 1; no done. A new start then completes cleanly with err = 0.
- Async reset mid-SHIFT: reset_n pulsed low between clock edges -> all outputs 0 immediately; busy = 0; start and abort ignored until reset_n is high; no done pulse.
